// File: rtl/shifter_pkg.sv
// Shared op encodings and width helpers for the pipelined shifter.
// Imported by shift_stage and pipelined_shifter.
package shifter_pkg;

   localparam logic [2:0] OP_SLL = 3'd0;
   localparam logic [2:0] OP_ROL = 3'd1;
   localparam logic [2:0] OP_SRL = 3'd2;
   localparam logic [2:0] OP_SRA = 3'd3;
   localparam logic [2:0] OP_ROR = 3'd4;

   // ceil(log2(w)); w is a power of two here, so this is exact.
   function automatic int log2w(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < w) r = i + 1;
      end
      return r;
   endfunction

   function automatic logic op_illegal(input logic [2:0] op);
      return op > OP_ROR;
   endfunction

   function automatic logic op_right(input logic [2:0] op);
      return (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log-step of the shifter: shifts by DIST when en is set.
// Optional sticky output (PIPELINED_SHIFTER_STICKY_EN) flags bits lost off bit 0.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] in_data,
   input  logic             en,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] out_data
`ifdef PIPELINED_SHIFTER_STICKY_EN
   ,
   output logic             sticky
`endif
);

   // Select the shifted/rotated form for this step; reserved ops pass through.
   always_comb begin
      out_data = in_data;
      if (en) begin
         case (op)
            OP_SLL:  out_data = {in_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            OP_ROL:  out_data = {in_data[WIDTH-DIST-1:0],
                                 in_data[WIDTH-1:WIDTH-DIST]};
            OP_SRL:  out_data = {{DIST{1'b0}}, in_data[WIDTH-1:DIST]};
            OP_SRA:  out_data = {{DIST{in_data[WIDTH-1]}},
                                 in_data[WIDTH-1:DIST]};
            OP_ROR:  out_data = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
            default: out_data = in_data;
         endcase
      end
   end

`ifdef PIPELINED_SHIFTER_STICKY_EN
   // Bits falling off the bottom only count for logical/arithmetic right shifts.
   always_comb begin
      sticky = en && op_right(op) && (|in_data[DIST-1:0]);
   end
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Two-register pipelined barrel shifter with valid/ready flow control.
// Optional macro PIPELINED_SHIFTER_STICKY_EN adds the out_sticky output.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SPLIT = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [log2w(WIDTH)-1:0]  in_amount,
   input  logic [2:0]               in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_result,
   output logic                     out_zero,
   output logic                     out_illegal
`ifdef PIPELINED_SHIFTER_STICKY_EN
   ,
   output logic                     out_sticky
`endif
);

   localparam int AW = log2w(WIDTH);
   localparam int HW = AW - SPLIT;

   logic                  s1_advance;

   logic                  s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]      s1_data_q, s1_data_d;
   logic [2:0]            s1_op_q, s1_op_d;
   logic [HW-1:0]         s1_amt_q, s1_amt_d;

   logic                  s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0]      s2_result_q, s2_result_d;
   logic                  s2_zero_q, s2_zero_d;
   logic                  s2_illegal_q, s2_illegal_d;

   logic [SPLIT:0][WIDTH-1:0] lo_chain;
   logic [HW:0][WIDTH-1:0]    hi_chain;

`ifdef PIPELINED_SHIFTER_STICKY_EN
   logic [SPLIT-1:0]      lo_stk;
   logic [HW-1:0]         hi_stk;
   logic                  s1_sticky_q, s1_sticky_d;
   logic                  s2_sticky_q, s2_sticky_d;
`endif

   assign lo_chain[0] = in_data;
   assign hi_chain[0] = s1_data_q;

   // Stage 1 applies the low amount bits straight off the input.
   for (genvar i = 0; i < SPLIT; i++) begin : g_lo
      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << i)
      ) u_stage (
         .in_data  (lo_chain[i]),
         .en       (in_amount[i]),
         .op       (in_op),
         .out_data (lo_chain[i+1])
`ifdef PIPELINED_SHIFTER_STICKY_EN
         ,
         .sticky   (lo_stk[i])
`endif
      );
   end

   // Stage 2 applies the remaining amount bits carried in s1_amt_q.
   for (genvar j = 0; j < HW; j++) begin : g_hi
      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << (SPLIT + j))
      ) u_stage (
         .in_data  (hi_chain[j]),
         .en       (s1_amt_q[j]),
         .op       (s1_op_q),
         .out_data (hi_chain[j+1])
`ifdef PIPELINED_SHIFTER_STICKY_EN
         ,
         .sticky   (hi_stk[j])
`endif
      );
   end

   // Backpressure depends only on stage state and out_ready, never in_valid.
   assign s1_advance = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s1_advance;

   // Stage 1 next state: load on accept, empty when advancing without input.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_op_d    = s1_op_q;
      s1_amt_d   = s1_amt_q;
`ifdef PIPELINED_SHIFTER_STICKY_EN
      s1_sticky_d = s1_sticky_q;
`endif
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d = lo_chain[SPLIT];
            s1_op_d   = in_op;
            s1_amt_d  = in_amount[AW-1:SPLIT];
`ifdef PIPELINED_SHIFTER_STICKY_EN
            s1_sticky_d = |lo_stk;
`endif
         end
      end
   end

   // Stage 2 next state: results are held while the consumer stalls.
   always_comb begin
      s2_valid_d   = s2_valid_q;
      s2_result_d  = s2_result_q;
      s2_zero_d    = s2_zero_q;
      s2_illegal_d = s2_illegal_q;
`ifdef PIPELINED_SHIFTER_STICKY_EN
      s2_sticky_d  = s2_sticky_q;
`endif
      if (s1_advance) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_result_d  = hi_chain[HW];
            s2_zero_d    = (hi_chain[HW] == '0);
            s2_illegal_d = op_illegal(s1_op_q);
`ifdef PIPELINED_SHIFTER_STICKY_EN
            s2_sticky_d  = s1_sticky_q | (|hi_stk);
`endif
         end
      end
   end

   // Pipeline registers; reset drops any in-flight work.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q   <= 1'b0;
         s1_data_q    <= '0;
         s1_op_q      <= '0;
         s1_amt_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_zero_q    <= 1'b0;
         s2_illegal_q <= 1'b0;
`ifdef PIPELINED_SHIFTER_STICKY_EN
         s1_sticky_q  <= 1'b0;
         s2_sticky_q  <= 1'b0;
`endif
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_data_q    <= s1_data_d;
         s1_op_q      <= s1_op_d;
         s1_amt_q     <= s1_amt_d;
         s2_valid_q   <= s2_valid_d;
         s2_result_q  <= s2_result_d;
         s2_zero_q    <= s2_zero_d;
         s2_illegal_q <= s2_illegal_d;
`ifdef PIPELINED_SHIFTER_STICKY_EN
         s1_sticky_q  <= s1_sticky_d;
         s2_sticky_q  <= s2_sticky_d;
`endif
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = s2_result_q;
   assign out_zero    = s2_zero_q;
   assign out_illegal = s2_illegal_q;
`ifdef PIPELINED_SHIFTER_STICKY_EN
   assign out_sticky  = s2_sticky_q;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter: 64-bit default and 32-bit/SPLIT=2.
// Vector table plus backpressure and mid-flight reset sequences.
module tb_pipelined_shifter;

   logic clock;
   logic reset;

   logic        iv_a, ir_a, ov_a, or_a, oz_a, oi_a;
   logic [63:0] id_a, res_a;
   logic [5:0]  am_a;
   logic [2:0]  op_a;

   logic        iv_b, ir_b, ov_b, or_b, oz_b, oi_b;
   logic [31:0] id_b, res_b;
   logic [4:0]  am_b;
   logic [2:0]  op_b;

`ifdef PIPELINED_SHIFTER_STICKY_EN
   logic stk_a, stk_b;
`endif

   int checks;
   int errors;

   pipelined_shifter #(.WIDTH(64), .SPLIT(3)) dut_a (
      .clock(clock), .reset(reset),
      .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
      .in_amount(am_a), .in_op(op_a),
      .out_valid(ov_a), .out_ready(or_a), .out_result(res_a),
      .out_zero(oz_a), .out_illegal(oi_a)
`ifdef PIPELINED_SHIFTER_STICKY_EN
      , .out_sticky(stk_a)
`endif
   );

   pipelined_shifter #(.WIDTH(32), .SPLIT(2)) dut_b (
      .clock(clock), .reset(reset),
      .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
      .in_amount(am_b), .in_op(op_b),
      .out_valid(ov_b), .out_ready(or_b), .out_result(res_b),
      .out_zero(oz_b), .out_illegal(oi_b)
`ifdef PIPELINED_SHIFTER_STICKY_EN
      , .out_sticky(stk_b)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        w32;
      logic [2:0]  op;
      logic [63:0] data;
      logic [5:0]  amt;
      logic [63:0] exp;
      logic        ez;
      logic        eil;
      logic        est;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string nm, input int idx,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [63:0] r;
      @(negedge clock);
      if (v.w32) begin
         iv_b = 1'b1; id_b = v.data[31:0]; am_b = v.amt[4:0]; op_b = v.op;
      end else begin
         iv_a = 1'b1; id_a = v.data; am_a = v.amt; op_a = v.op;
      end
      #1;
      chk("in_ready", idx, v.w32 ? ir_b : ir_a, 1);
      @(posedge clock); #1;
      iv_a = 1'b0; iv_b = 1'b0;
      chk("lat1_valid", idx, v.w32 ? ov_b : ov_a, 0);
      @(posedge clock); #1;
      r = v.w32 ? {32'h0, res_b} : res_a;
      chk("lat2_valid", idx, v.w32 ? ov_b : ov_a, 1);
      chk("result", idx, r, v.exp);
      chk("zero", idx, v.w32 ? oz_b : oz_a, v.ez);
      chk("illegal", idx, v.w32 ? oi_b : oi_a, v.eil);
`ifdef PIPELINED_SHIFTER_STICKY_EN
      chk("sticky", idx, v.w32 ? stk_b : stk_a, v.est);
`endif
   endtask

   logic [63:0] bp_exp [3];
   int acc;
   int stale;

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1;
      iv_a = 0; id_a = '0; am_a = '0; op_a = '0; or_a = 1'b1;
      iv_b = 0; id_b = '0; am_b = '0; op_b = '0; or_b = 1'b1;

      tv[0]  = '{0, 3'd3, 64'h8000_0000_0000_0000, 6'd4,
                 64'hF800_0000_0000_0000, 0, 0, 0};
      tv[1]  = '{0, 3'd4, 64'h1, 6'd1, 64'h8000_0000_0000_0000, 0, 0, 0};
      tv[2]  = '{0, 3'd0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 0, 0, 0};
      tv[3]  = '{0, 3'd2, 64'hFF, 6'd8, 64'h0, 1, 0, 1};
      tv[4]  = '{0, 3'd3, 64'h8000_0000_0000_00F0, 6'd0,
                 64'h8000_0000_0000_00F0, 0, 0, 0};
      tv[5]  = '{0, 3'd1, 64'h0123_4567_89AB_CDEF, 6'd8,
                 64'h2345_6789_ABCD_EF01, 0, 0, 0};
      tv[6]  = '{0, 3'd2, 64'h0123_4567_89AB_CDEF, 6'd4,
                 64'h0012_3456_789A_BCDE, 0, 0, 1};
      tv[7]  = '{0, 3'd7, 64'hDEAD, 6'd5, 64'hDEAD, 0, 1, 0};
      tv[8]  = '{0, 3'd3, 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 64'h0, 1, 0, 1};
      tv[9]  = '{0, 3'd4, 64'h0123_4567_89AB_CDEF, 6'd12,
                 64'hDEF0_1234_5678_9ABC, 0, 0, 0};
      tv[10] = '{0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd36,
                 64'hFFFF_FFF0_0000_0000, 0, 0, 0};
      tv[11] = '{1, 3'd1, 64'h8000_0001, 6'd4, 64'h18, 0, 0, 0};
      tv[12] = '{1, 3'd6, 64'h1234, 6'd3, 64'h1234, 0, 1, 0};
      tv[13] = '{1, 3'd3, 64'h8000_0000, 6'd31, 64'hFFFF_FFFF, 0, 0, 0};
      tv[14] = '{1, 3'd4, 64'h1234_5678, 6'd16, 64'h5678_1234, 0, 0, 0};

      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_out_valid_a", 0, ov_a, 0);
      chk("rst_in_ready_a", 0, ir_a, 1);
      chk("rst_result_a", 0, res_a, 0);
      chk("rst_zero_a", 0, oz_a, 0);
      chk("rst_out_valid_b", 0, ov_b, 0);
      chk("rst_in_ready_b", 0, ir_b, 1);

      for (int i = 0; i < 15; i++) run_vec(tv[i], i);

      // Backpressure: out_ready low 4 cycles, 3 inputs offered.
      bp_exp[0] = 64'h2; bp_exp[1] = 64'h4; bp_exp[2] = 64'h8;
      @(posedge clock);
      or_a = 1'b0;
      acc = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         iv_a = 1'b1; id_a = 64'h1; op_a = 3'd0;
         am_a = 6'(acc + 1);
         #1;
         if (ir_a) acc++;
         @(posedge clock);
      end
      #1;
      chk("bp_accepted", 0, 64'(acc), 2);
      chk("bp_in_ready", 0, ir_a, 0);
      chk("bp_out_valid", 0, ov_a, 1);
      chk("bp_hold_result", 0, res_a, bp_exp[0]);
      @(negedge clock);
      or_a = 1'b1;
      #1;
      chk("bp_in_ready_drain", 0, ir_a, 1);
      @(posedge clock); #1;
      chk("bp_valid1", 1, ov_a, 1);
      chk("bp_result1", 1, res_a, bp_exp[1]);
      @(negedge clock);
      iv_a = 1'b0;
      @(posedge clock); #1;
      chk("bp_valid2", 2, ov_a, 1);
      chk("bp_result2", 2, res_a, bp_exp[2]);
      @(posedge clock); #1;
      chk("bp_empty", 3, ov_a, 0);

      // Reset with both stages full.
      @(negedge clock);
      or_a = 1'b0;
      iv_a = 1'b1; id_a = 64'hF0; am_a = 6'd0; op_a = 3'd0;
      @(posedge clock);
      @(negedge clock);
      id_a = 64'h0F;
      @(posedge clock);
      #1;
      chk("pre_rst_valid", 0, ov_a, 1);
      @(negedge clock);
      reset = 1'b1;
      id_a = 64'hAA;
      @(posedge clock); #1;
      chk("mid_rst_out_valid", 0, ov_a, 0);
      chk("mid_rst_in_ready", 0, ir_a, 1);
      chk("mid_rst_result", 0, res_a, 0);
      chk("mid_rst_illegal", 0, oi_a, 0);
      @(negedge clock);
      reset = 1'b0; iv_a = 1'b0; or_a = 1'b1;
      stale = 0;
      repeat (6) begin
         @(posedge clock); #1;
         if (ov_a) stale++;
      end
      chk("no_stale", 0, 64'(stale), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
